// File: rtl/cmd_arbiter_dispatch.sv
// Round-robin arbiter that shares one control_unit command port between NUM_REQ requesters
// and routes each done_irq completion back to the owner of the oldest in-flight command.
module cmd_arbiter_dispatch #(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned CMD_WIDTH    = 64,
  parameter int unsigned MAX_INFLIGHT = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ*CMD_WIDTH-1:0]       req_cmd,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic [NUM_REQ-1:0]                 req_done,
  output logic                               cmd_valid,
  output logic [CMD_WIDTH-1:0]               cmd_data,
  input  logic                               cmd_ready,
  input  logic                               done_irq,
  output logic [$clog2(MAX_INFLIGHT+1)-1:0]  inflight_cnt,
  output logic                               err_spurious
);

  localparam int unsigned IdW  = $clog2(NUM_REQ);
  localparam int unsigned PtrW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int unsigned CntW = $clog2(MAX_INFLIGHT + 1);

  localparam logic [IdW-1:0]  RrLast  = IdW'(NUM_REQ - 1);
  localparam logic [PtrW-1:0] PtrLast = PtrW'(MAX_INFLIGHT - 1);
  localparam logic [CntW-1:0] MaxCnt  = CntW'(MAX_INFLIGHT);

  typedef enum logic [0:0] {StIdle, StIssue} state_e;

  state_e          state_q;
  logic [IdW-1:0]  rr_ptr_q;
  logic [IdW-1:0]  own_id_q;
  logic            done_irq_q;
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [IdW-1:0]  tag_mem [MAX_INFLIGHT];

  logic                 grant;
  logic [IdW-1:0]       winner;
  logic [IdW-1:0]       hi_idx;
  logic [IdW-1:0]       lo_idx;
  logic                 hi_found;
  logic [CMD_WIDTH-1:0] win_cmd;
  logic                 done_rise;
  logic                 fifo_empty;
  logic                 push;
  logic                 pop;
  logic [IdW-1:0]       head_id;

  // Round-robin search: lowest valid index at or above rr_ptr, else lowest valid overall.
  always_comb begin
    hi_idx   = '0;
    lo_idx   = '0;
    hi_found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_idx = IdW'(i);
        if (IdW'(i) >= rr_ptr_q) begin
          hi_idx   = IdW'(i);
          hi_found = 1'b1;
        end
      end
    end
    winner = hi_found ? hi_idx : lo_idx;
  end

  assign win_cmd    = req_cmd[winner*CMD_WIDTH +: CMD_WIDTH];
  assign grant      = !rst && (state_q == StIdle) && (|req_valid) && (inflight_cnt < MaxCnt);
  assign done_rise  = done_irq & ~done_irq_q;
  assign fifo_empty = (inflight_cnt == '0);
  assign push       = (state_q == StIssue) && cmd_ready;
  assign pop        = done_rise && !fifo_empty;
  assign head_id    = tag_mem[rd_ptr_q];

  always_comb begin
    req_ready = '0;
    if (grant) begin
      req_ready[winner] = 1'b1;
    end
  end

  // Tag storage needs no reset: occupancy and pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_mem[wr_ptr_q] <= own_id_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      own_id_q     <= '0;
      cmd_valid    <= 1'b0;
      cmd_data     <= '0;
      done_irq_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      inflight_cnt <= '0;
      req_done     <= '0;
      err_spurious <= 1'b0;
    end else begin
      done_irq_q   <= done_irq;
      err_spurious <= done_rise && fifo_empty;

      req_done <= '0;
      if (pop) begin
        req_done[head_id] <= 1'b1;
      end

      if (push) begin
        wr_ptr_q <= (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
      end

      unique case ({push, pop})
        2'b10:   inflight_cnt <= inflight_cnt + 1'b1;
        2'b01:   inflight_cnt <= inflight_cnt - 1'b1;
        default: inflight_cnt <= inflight_cnt;
      endcase

      unique case (state_q)
        StIdle: begin
          if (grant) begin
            state_q   <= StIssue;
            cmd_valid <= 1'b1;
            cmd_data  <= win_cmd;
            own_id_q  <= winner;
            rr_ptr_q  <= (winner == RrLast) ? '0 : winner + 1'b1;
          end
        end
        StIssue: begin
          if (cmd_ready) begin
            state_q   <= StIdle;
            cmd_valid <= 1'b0;
          end
        end
        default: begin
          state_q   <= StIdle;
          cmd_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_arbiter_dispatch.sv
// Randomized bench for cmd_arbiter_dispatch, checked every cycle against a queue-based
// model of arbitration, command hand-off and in-order completion routing.
module tb_cmd_arbiter_dispatch;

  localparam int N = 2;
  localparam int W = 64;
  localparam int M = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_cmd;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   req_done;
  logic           cmd_valid;
  logic [W-1:0]   cmd_data;
  logic           cmd_ready;
  logic           done_irq;
  logic [2:0]     inflight_cnt;
  logic           err_spurious;

  always #5 clk = ~clk;

  cmd_arbiter_dispatch #(
    .NUM_REQ      (N),
    .CMD_WIDTH    (W),
    .MAX_INFLIGHT (M)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_cmd      (req_cmd),
    .req_ready    (req_ready),
    .req_done     (req_done),
    .cmd_valid    (cmd_valid),
    .cmd_data     (cmd_data),
    .cmd_ready    (cmd_ready),
    .done_irq     (done_irq),
    .inflight_cnt (inflight_cnt),
    .err_spurious (err_spurious)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a command slot, an owner queue and a round-robin index.
  bit           m_busy;
  logic [W-1:0] m_cmd;
  int           m_id;
  int           m_rr;
  int           m_q[$];
  bit           m_prev_done;
  logic [N-1:0] m_done;
  bit           m_err;

  task automatic model_reset();
    m_busy      = 1'b0;
    m_cmd       = '0;
    m_id        = 0;
    m_rr        = 0;
    m_q         = {};
    m_prev_done = 1'b0;
    m_done      = '0;
    m_err       = 1'b0;
  endtask

  function automatic int pick_winner(input logic [N-1:0] v, input int rr);
    for (int k = 0; k < N; k++) begin
      if (v[(rr + k) % N]) return (rr + k) % N;
    end
    return -1;
  endfunction

  // Per-phase probabilities (percent): done_irq toggle, cmd_ready high, req bit valid.
  int p_done  [4] = '{25, 4, 60, 30};
  int p_ready [4] = '{70, 80, 60, 15};
  int p_valid [4] = '{70, 90, 40, 80};
  int p_len   [4] = '{800, 600, 400, 500};

  initial begin
    int           w;
    logic [N-1:0] exp_ready;
    rst       = 1'b1;
    req_valid = '0;
    req_cmd   = '0;
    cmd_ready = 1'b0;
    done_irq  = 1'b0;
    repeat (2) @(posedge clk);
    model_reset();

    for (int ph = 0; ph < 4; ph++) begin
      for (int cyc = 0; cyc < p_len[ph]; cyc++) begin
        @(negedge clk);
        rst = (cyc == 0 && ph == 0) ? 1'b1 : ($urandom_range(0, 149) == 0);
        for (int i = 0; i < N; i++) begin
          req_valid[i]       = ($urandom_range(0, 99) < p_valid[ph]);
          req_cmd[i*W +: W]  = {$urandom, $urandom};
        end
        cmd_ready = ($urandom_range(0, 99) < p_ready[ph]);
        if ($urandom_range(0, 99) < p_done[ph]) done_irq = ~done_irq;
        #1;

        exp_ready = '0;
        w = -1;
        if (!rst && !m_busy && m_q.size() < M) w = pick_winner(req_valid, m_rr);
        if (w >= 0) exp_ready[w] = 1'b1;

        check_eq("req_ready", 64'(req_ready), 64'(exp_ready));
        check_eq("cmd_valid", 64'(cmd_valid), 64'(m_busy));
        if (m_busy) check_eq("cmd_data", cmd_data, m_cmd);
        check_eq("inflight_cnt", 64'(inflight_cnt), 64'(m_q.size()));
        check_eq("req_done", 64'(req_done), 64'(m_done));
        check_eq("err_spurious", 64'(err_spurious), 64'(m_err));

        if (rst) begin
          model_reset();
        end else begin
          m_done = '0;
          m_err  = 1'b0;
          if (done_irq && !m_prev_done) begin
            if (m_q.size() > 0) m_done[m_q.pop_front()] = 1'b1;
            else m_err = 1'b1;
          end
          m_prev_done = done_irq;
          if (m_busy) begin
            if (cmd_ready) begin
              m_q.push_back(m_id);
              m_busy = 1'b0;
            end
          end else if (w >= 0) begin
            m_busy = 1'b1;
            m_id   = w;
            m_cmd  = req_cmd[w*W +: W];
            m_rr   = (w + 1) % N;
          end
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
